// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for a 12-bit MCP4921-class DAC.
// Frames each 8-bit sample with a one-deep pending buffer and an LDAC pulse.
module dac_spi_tx #(
  parameter int         CLK_DIV = 4,
  parameter logic [3:0] CFG     = 4'b0011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_mosi,
  output logic       dac_ldac_n,
  output logic       busy,
  output logic       overrun
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CSHI,
    LDAC
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [3:0]    bit_cnt, bit_n;
  logic          phase, phase_n;
  logic [15:0]   sreg, sreg_n;
  logic [15:0]   pword, pword_n;
  logic          pend_full, pend_n;
  logic          ovr_n;
  logic          launch;
  logic          div_last;

  function automatic logic [15:0] frame_word(
    input logic [7:0] s
  );
    return {CFG, s, 4'h0};
  endfunction

  assign div_last = (div_cnt == DIV_LAST);

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    phase_n = phase;
    sreg_n  = sreg;
    pword_n = pword;
    pend_n  = pend_full;
    ovr_n   = 1'b0;
    launch  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_full) begin
          launch  = 1'b1;
          sreg_n  = pword;
          pend_n  = 1'b0;
          state_n = SHIFT;
        end else if (sample_valid) begin
          sreg_n  = frame_word(sample_in);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (!div_last) begin
          div_n = div_cnt + 1'b1;
        end else begin
          div_n   = '0;
          phase_n = ~phase;
          // a bit ends after its high phase
          if (phase) begin
            sreg_n = {sreg[14:0], 1'b0};
            bit_n  = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) state_n = CSHI;
          end
        end
      end
      CSHI: begin
        if (!div_last) begin
          div_n = div_cnt + 1'b1;
        end else begin
          div_n   = '0;
          state_n = LDAC;
        end
      end
      LDAC: begin
        if (!div_last) begin
          div_n = div_cnt + 1'b1;
        end else begin
          div_n = '0;
          if (pend_full) begin
            launch  = 1'b1;
            sreg_n  = pword;
            pend_n  = 1'b0;
            state_n = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // a strobe that cannot start a frame now goes to the pending slot
    if (sample_valid && (state != IDLE || pend_full)) begin
      pword_n = frame_word(sample_in);
      pend_n  = 1'b1;
      ovr_n   = pend_full && !launch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      phase      <= 1'b0;
      sreg       <= '0;
      pword      <= '0;
      pend_full  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_mosi   <= 1'b0;
      dac_ldac_n <= 1'b1;
    end else begin
      state      <= state_n;
      div_cnt    <= div_n;
      bit_cnt    <= bit_n;
      phase      <= phase_n;
      sreg       <= sreg_n;
      pword      <= pword_n;
      pend_full  <= pend_n;
      overrun    <= ovr_n;
      busy       <= (state_n != IDLE) || pend_n;
      dac_cs_n   <= (state_n != SHIFT);
      dac_sclk   <= (state_n == SHIFT) && phase_n;
      dac_mosi   <= (state_n == SHIFT) && sreg_n[15];
      dac_ldac_n <= (state_n != LDAC);
    end
  end

endmodule
